ul_frame_collector: RTL and testbench



---
 rtl/ul_frame_collector_if.sv | 60 ++++++
 rtl/ul_frame_collector.sv | 212 +++++++++++++++++++++
 tb/tb_ul_frame_collector.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ul_frame_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : ul_frame_collector_if
// Description : Bundle between the UART RX byte path, the uplink frame
//               collector and the uplink FEC engine.
//               Signals:
//                 enc_used    frame mode (0 = 64-bit cluster, 1 = 16-bit)
//                 rx_valid    RX byte valid
//                 rx_data     RX byte
//                 rx_ready    collector can accept a byte
//                 data_out    payload bytes d0..d6 (index 0 = first after SOF)
//                 enc_used_o  mode latched at SOF
//                 enc0_*      64-bit cluster start/parity, crc0_data CRC byte
//                 enc1_*      16-bit cluster start/parity, crc1_data CRC nibble
//                 crc0_done   64-bit cluster CRC done (from engine)
//                 crc1_done   16-bit cluster CRC done (from engine)
//                 frame_done  frame fully processed (pulse)
//                 frame_err   frame aborted by timeout (pulse)
//                 sof_drop    non-SOF byte discarded while hunting (pulse)
//               Modports: slave = collector side, master = RX/engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ul_frame_collector_if;
  logic            enc_used;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_ready;
  logic [6:0][7:0] data_out;
  logic            enc_used_o;
  logic            enc0_start;
  logic [7:0]      enc0_row_p;
  logic [7:0]      enc0_col_p;
  logic [7:0]      crc0_data;
  logic            enc1_start;
  logic [3:0]      enc1_row_p;
  logic [3:0]      enc1_col_p;
  logic [3:0]      crc1_data;
  logic            crc0_done;
  logic            crc1_done;
  logic            frame_done;
  logic            frame_err;
  logic            sof_drop;

  modport slave (
    input  enc_used, rx_valid, rx_data, crc0_done, crc1_done,
    output rx_ready, data_out, enc_used_o,
    output enc0_start, enc0_row_p, enc0_col_p, crc0_data,
    output enc1_start, enc1_row_p, enc1_col_p, crc1_data,
    output frame_done, frame_err, sof_drop
  );

  modport master (
    output enc_used, rx_valid, rx_data, crc0_done, crc1_done,
    input  rx_ready, data_out, enc_used_o,
    input  enc0_start, enc0_row_p, enc0_col_p, crc0_data,
    input  enc1_start, enc1_row_p, enc1_col_p, crc1_data,
    input  frame_done, frame_err, sof_drop
  );
endinterface
`default_nettype wire

// File: rtl/ul_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : ul_frame_collector
// Description : Uplink framing stage in front of the uplink FEC engine.
//               Hunts for SOF_BYTE, collects an 11-byte (64-bit cluster) or
//               6-byte (16-bit cluster) frame selected by enc_used, then
//               pulses the matching engine start and holds all outputs while
//               back-pressuring RX until the engine reports CRC done.
//               Ports:
//                 clk    system clock
//                 rst_n  asynchronous active-low reset
//                 bus    ul_frame_collector_if.slave (RX stream, engine
//                        payload/parity/CRC/start, done inputs, status pulses)
//               Optional feature macro: UL_FRAME_TIMEOUT_EN
//                 defined   -> inter-byte timeout aborts a stalled frame and
//                              pulses frame_err
//                 undefined -> no timeout logic, frame_err is always 0
// Revision    : 1.0 - initial release
// ============================================================================
module ul_frame_collector #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  ul_frame_collector_if.slave bus
);

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_collect   = 2'd1;
  localparam logic [1:0] c_st_start     = 2'd2;
  localparam logic [1:0] c_st_wait_done = 2'd3;

  // Index of the final byte after SOF for each frame mode.
  localparam logic [3:0] c_last_idx_m0  = 4'd9;
  localparam logic [3:0] c_last_idx_m1  = 4'd4;

  logic [1:0]      r_state;
  logic            r_alive;
  logic [3:0]      r_idx;
  logic            r_enc_used;
  logic [6:0][7:0] r_data;
  logic [7:0]      r_crc0;
  logic [7:0]      r_row0;
  logic [7:0]      r_col0;
  logic [3:0]      r_crc1;
  logic [3:0]      r_row1;
  logic [3:0]      r_col1;
  logic            r_enc0_start;
  logic            r_enc1_start;
  logic            r_frame_done;
  logic            r_frame_err;
  logic            r_sof_drop;

  logic            w_rx_ready;
  logic            w_accept;
  logic            w_last;
  logic            w_done;
  logic            w_timeout;

  // r_alive keeps rx_ready low while reset is applied; it rises on the first
  // clock after release.
  assign w_rx_ready = r_alive & ((r_state == c_st_idle) | (r_state == c_st_collect));
  assign w_accept   = bus.rx_valid & w_rx_ready;
  assign w_last     = r_enc_used ? (r_idx == c_last_idx_m1) : (r_idx == c_last_idx_m0);
  // Only the done belonging to the latched mode ends the frame.
  assign w_done     = r_enc_used ? bus.crc1_done : bus.crc0_done;

`ifdef UL_FRAME_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  // Counts idle cycles inside COLLECT; any other state or an accept clears it,
  // so a fresh SOF always starts the window from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == c_st_collect) && !w_accept) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  // An accept in the expiry cycle wins over the timeout.
  assign w_timeout = (r_state == c_st_collect) && !w_accept &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Timeout parameters stay referenced so both builds share one interface.
  logic [TO_W-1:0] w_unused_to_limit;
  assign w_unused_to_limit = TO_W'(TIMEOUT_CYCLES - 1);
  assign w_timeout         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_alive      <= 1'b0;
      r_idx        <= '0;
      r_enc_used   <= 1'b0;
      r_data       <= '0;
      r_crc0       <= '0;
      r_row0       <= '0;
      r_col0       <= '0;
      r_crc1       <= '0;
      r_row1       <= '0;
      r_col1       <= '0;
      r_enc0_start <= 1'b0;
      r_enc1_start <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_sof_drop   <= 1'b0;
    end else begin
      r_alive      <= 1'b1;
      r_enc0_start <= 1'b0;
      r_enc1_start <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_sof_drop   <= 1'b0;

      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            if (bus.rx_data == SOF_BYTE) begin
              r_enc_used <= bus.enc_used;
              r_idx      <= '0;
              r_data     <= '0;
              r_crc0     <= '0;
              r_row0     <= '0;
              r_col0     <= '0;
              r_crc1     <= '0;
              r_row1     <= '0;
              r_col1     <= '0;
              r_state    <= c_st_collect;
            end else begin
              r_sof_drop <= 1'b1;
            end
          end
        end

        c_st_collect: begin
          if (w_accept) begin
            // Inside a frame every byte is positional; SOF_BYTE is plain data.
            if (!r_enc_used) begin
              case (r_idx)
                4'd7:    r_crc0 <= bus.rx_data;
                4'd8:    r_row0 <= bus.rx_data;
                4'd9:    r_col0 <= bus.rx_data;
                default: if (r_idx < 4'd7) r_data[r_idx[2:0]] <= bus.rx_data;
              endcase
            end else begin
              case (r_idx)
                4'd3: r_crc1 <= bus.rx_data[3:0];
                4'd4: begin
                  r_row1 <= bus.rx_data[3:0];
                  r_col1 <= bus.rx_data[7:4];
                end
                default: if (r_idx < 4'd3) r_data[r_idx[2:0]] <= bus.rx_data;
              endcase
            end
            r_idx <= r_idx + 4'd1;
            if (w_last) begin
              r_state      <= c_st_start;
              r_enc0_start <= ~r_enc_used;
              r_enc1_start <= r_enc_used;
            end
          end else if (w_timeout) begin
            // Partial contents are left in the output registers.
            r_state     <= c_st_idle;
            r_frame_err <= 1'b1;
          end
        end

        // A done arriving while the start pulse is still out is honoured.
        c_st_start: begin
          if (w_done) begin
            r_state      <= c_st_idle;
            r_frame_done <= 1'b1;
          end else begin
            r_state <= c_st_wait_done;
          end
        end

        c_st_wait_done: begin
          if (w_done) begin
            r_state      <= c_st_idle;
            r_frame_done <= 1'b1;
          end
        end

        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.data_out   = r_data;
  assign bus.enc_used_o = r_enc_used;
  assign bus.enc0_start = r_enc0_start;
  assign bus.enc0_row_p = r_row0;
  assign bus.enc0_col_p = r_col0;
  assign bus.crc0_data  = r_crc0;
  assign bus.enc1_start = r_enc1_start;
  assign bus.enc1_row_p = r_row1;
  assign bus.enc1_col_p = r_col1;
  assign bus.crc1_data  = r_crc1;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.sof_drop   = r_sof_drop;

endmodule
`default_nettype wire

// File: tb/tb_ul_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_ul_frame_collector
// Description : Self-checking bench for ul_frame_collector. A frame-level
//               reference (list of bytes received after SOF, phase of the
//               frame, pending pulses) predicts every output on every cycle;
//               directed frames add literal expectations, then randomized
//               traffic with gaps, garbage and done noise follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ul_frame_collector;
  localparam int         TO_CYC = 16;
  localparam logic [7:0] SOF    = 8'hA5;

  localparam int PH_HUNT = 0, PH_COLLECT = 1, PH_START = 2, PH_WAIT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ul_frame_collector_if bus();

  ul_frame_collector #(
    .SOF_BYTE      (SOF),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_s0 = 0, n_s1 = 0, n_done = 0, n_err = 0, n_drop = 0;

  // done responder controls
  int done_delay  = 0;
  bit wrong_pulse = 1'b0;
  bit noise_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_alive;
  int         m_phase;
  bit         m_mode;
  logic [7:0] m_frame[$];
  int         m_cyc  = 0;
  int         m_last = 0;
  bit         m_s0, m_s1, m_done, m_err, m_drop;

  function automatic bit m_ready();
    return m_alive && (m_phase == PH_HUNT || m_phase == PH_COLLECT);
  endfunction

  function automatic logic [7:0] e_byte(input int i);
    return (i < m_frame.size()) ? m_frame[i] : 8'h00;
  endfunction

  function automatic logic [55:0] e_data();
    logic [55:0] d;
    int lim;
    d   = '0;
    lim = m_mode ? 3 : 7;
    for (int i = 0; i < lim; i++) d[i*8 +: 8] = e_byte(i);
    return d;
  endfunction

  task automatic mdl_reset();
    m_alive = 1'b0; m_phase = PH_HUNT; m_mode = 1'b0;
    m_frame.delete();
    m_s0 = 0; m_s1 = 0; m_done = 0; m_err = 0; m_drop = 0;
  endtask

  // Advance across the coming clock edge using the inputs now on the bus.
  task automatic mdl_step();
    bit acc, dn;
    acc = bus.rx_valid && m_ready();
    dn  = m_mode ? bus.crc1_done : bus.crc0_done;
    m_s0 = 0; m_s1 = 0; m_done = 0; m_err = 0; m_drop = 0;
    m_cyc++;
    if (!m_alive) begin
      m_alive = 1'b1;
    end else begin
      case (m_phase)
        PH_HUNT: if (acc) begin
          if (bus.rx_data == SOF) begin
            m_frame.delete(); m_mode = bus.enc_used; m_phase = PH_COLLECT; m_last = m_cyc;
          end else m_drop = 1;
        end
        PH_COLLECT: begin
          if (acc) begin
            m_frame.push_back(bus.rx_data);
            m_last = m_cyc;
            if (m_frame.size() == (m_mode ? 5 : 10)) begin
              m_phase = PH_START;
              if (m_mode) m_s1 = 1; else m_s0 = 1;
            end
          end
`ifdef UL_FRAME_TIMEOUT_EN
          else if (m_cyc - m_last == TO_CYC) begin
            m_phase = PH_HUNT; m_err = 1;
          end
`endif
        end
        default: begin
          if (dn) begin m_phase = PH_HUNT; m_done = 1; end
          else m_phase = PH_WAIT;
        end
      endcase
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [7:0] b3, b4;
    mdl_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) mdl_reset();
      b3 = e_byte(3);
      b4 = e_byte(4);
      chk("rx_ready",   64'(bus.rx_ready),   64'(m_ready()));
      chk("data_out",   64'(bus.data_out),   64'(e_data()));
      chk("enc_used_o", 64'(bus.enc_used_o), 64'(m_mode));
      chk("crc0_data",  64'(bus.crc0_data),  64'(m_mode ? 8'h00 : e_byte(7)));
      chk("enc0_row_p", 64'(bus.enc0_row_p), 64'(m_mode ? 8'h00 : e_byte(8)));
      chk("enc0_col_p", 64'(bus.enc0_col_p), 64'(m_mode ? 8'h00 : e_byte(9)));
      chk("crc1_data",  64'(bus.crc1_data),  64'(m_mode ? b3[3:0] : 4'h0));
      chk("enc1_row_p", 64'(bus.enc1_row_p), 64'(m_mode ? b4[3:0] : 4'h0));
      chk("enc1_col_p", 64'(bus.enc1_col_p), 64'(m_mode ? b4[7:4] : 4'h0));
      chk("pulses", 64'({bus.enc0_start, bus.enc1_start, bus.frame_done, bus.frame_err, bus.sof_drop}),
                    64'({m_s0, m_s1, m_done, m_err, m_drop}));
      n_s0   += int'(bus.enc0_start);
      n_s1   += int'(bus.enc1_start);
      n_done += int'(bus.frame_done);
      n_err  += int'(bus.frame_err);
      n_drop += int'(bus.sof_drop);
      if (rst_n) mdl_step();
    end
  end

  // ---------------- FEC engine done responder ----------------
  initial begin
    bit armed, amode;
    int cnt, since;
    armed = 0; amode = 0; cnt = 0; since = 0;
    bus.crc0_done = 1'b0;
    bus.crc1_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.crc0_done = 1'b0;
      bus.crc1_done = 1'b0;
      if (!rst_n) begin
        armed = 0;
      end else begin
        if (bus.enc0_start || bus.enc1_start) begin
          armed = 1; amode = bus.enc1_start; cnt = done_delay; since = 0;
        end
        if (armed) begin
          if (wrong_pulse && since == 2) begin
            if (amode) bus.crc0_done = 1'b1; else bus.crc1_done = 1'b1;
          end
          if (cnt == 0) begin
            if (amode) bus.crc1_done = 1'b1; else bus.crc0_done = 1'b1;
            armed = 0;
          end else cnt--;
          since++;
        end
        if (noise_en && $urandom_range(0, 5) == 0) begin
          if (amode) bus.crc0_done = 1'b1; else bus.crc1_done = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    int n;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    got = 0; n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.rx_valid = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte: byte %h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_frame(input bit mode, input logic [7:0] body[$], input int gap, input bit rnd);
    int g;
    bus.enc_used = mode;
    send_byte(SOF, gap);
    foreach (body[i]) begin
      g = gap;
      if (rnd) begin
        bus.enc_used = 1'($urandom_range(0, 1));
        g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      end
      send_byte(body[i], g);
    end
  endtask

  task automatic wait_frame_done(input int maxc);
    int n0, k;
    n0 = n_done; k = 0;
    while (n_done == n0 && k < maxc) begin @(posedge clk); #1; k++; end
    chk("frame_done_seen", 64'(n_done - n0), 64'd1);
  endtask

  initial begin
    logic [7:0] q0[$], q1[$], qr[$], q5[$], qt[$], qb[$];
    int s0, s1, dr, er, dn;
    logic [7:0] g;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.enc_used = 1'b0;
    q0 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hC3, 8'h5A, 8'h0F};
    q1 = '{8'h0A, 8'h0B, 8'h0C, 8'h07, 8'h9E};
    qr = '{8'h00, 8'h11, 8'h22, 8'hA5, 8'h44, 8'h55, 8'h66, 8'hC3, 8'h5A, 8'h0F};
    q5 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h81, 8'h92, 8'hA3};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("reset_data_out", 64'(bus.data_out), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("ready_after_reset", 64'(bus.rx_ready), 64'd1);

    // mode 0 back-to-back, done 20 cycles after start
    done_delay = 20; s0 = n_s0; s1 = n_s1;
    send_frame(1'b0, q0, 0, 0);
    wait_frame_done(60);
    chk("m0_data_out", 64'(bus.data_out), 64'h0066_5544_3322_1100);
    chk("m0_crc0", 64'(bus.crc0_data), 64'hC3);
    chk("m0_row0", 64'(bus.enc0_row_p), 64'h5A);
    chk("m0_col0", 64'(bus.enc0_col_p), 64'h0F);
    chk("m0_start0_count", 64'(n_s0 - s0), 64'd1);
    chk("m0_start1_count", 64'(n_s1 - s1), 64'd0);
    chk("m0_ready_after_done", 64'(bus.rx_ready), 64'd1);

    // mode 1 with a stray crc0_done inside the wait
    done_delay = 10; wrong_pulse = 1'b1; s0 = n_s0; s1 = n_s1;
    send_frame(1'b1, q1, 0, 0);
    wait_frame_done(60);
    wrong_pulse = 1'b0;
    chk("m1_data_out", 64'(bus.data_out), 64'h0C_0B0A);
    chk("m1_crc1", 64'(bus.crc1_data), 64'h7);
    chk("m1_row1", 64'(bus.enc1_row_p), 64'hE);
    chk("m1_col1", 64'(bus.enc1_col_p), 64'h9);
    chk("m1_start1_count", 64'(n_s1 - s1), 64'd1);
    chk("m1_start0_count", 64'(n_s0 - s0), 64'd0);

    // resync: two garbage bytes, then a frame carrying A5 at idx 3
    done_delay = 3; dr = n_drop;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_frame(1'b0, qr, 0, 0);
    wait_frame_done(60);
    chk("resync_drops", 64'(n_drop - dr), 64'd2);
    chk("resync_data_out", 64'(bus.data_out), 64'h0066_5544_A522_1100);

    // back-pressure: a byte held valid during WAIT_DONE waits for the done
    done_delay = 15; dn = n_done; dr = n_drop;
    send_frame(1'b0, q0, 0, 0);
    send_byte(8'h77, 0);
    @(posedge clk); #1;
    chk("bp_done_count", 64'(n_done - dn), 64'd1);
    chk("bp_drop_count", 64'(n_drop - dr), 64'd1);
    chk("bp_data_held", 64'(bus.data_out), 64'h0066_5544_3322_1100);

    // 5-cycle gaps between bytes
    done_delay = 4;
    send_frame(1'b0, q5, 5, 0);
    wait_frame_done(200);
    chk("gap_data_out", 64'(bus.data_out), 64'h0070_6050_4030_2010);
    chk("gap_crc0", 64'(bus.crc0_data), 64'h81);
    chk("gap_row_col", 64'({bus.enc0_row_p, bus.enc0_col_p}), 64'h92A3);

    // stalled frame: SOF, 01, 02 then silence
    s0 = n_s0; er = n_err;
    bus.enc_used = 1'b0;
    send_byte(SOF, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    repeat (20) begin @(posedge clk); #1; end
`ifdef UL_FRAME_TIMEOUT_EN
    chk("to_err_count", 64'(n_err - er), 64'd1);
    chk("to_no_start", 64'(n_s0 - s0), 64'd0);
    send_frame(1'b0, q0, 0, 0);
    wait_frame_done(60);
    chk("to_next_frame", 64'(bus.data_out), 64'h0066_5544_3322_1100);
`else
    chk("to_no_err", 64'(n_err - er), 64'd0);
    qt = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    foreach (qt[i]) send_byte(qt[i], 0);
    wait_frame_done(60);
    chk("to_off_data_out", 64'(bus.data_out), 64'h0007_0605_0403_0201);
    chk("to_off_crc0", 64'(bus.crc0_data), 64'h08);
`endif

    // reset in the middle of a frame (counter at 5)
    bus.enc_used = 1'b0;
    send_byte(SOF, 0);
    qb = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (qb[i]) send_byte(qb[i], 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_data_out", 64'(bus.data_out), 64'd0);
    chk("midreset_ready", 64'(bus.rx_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done_delay = 2;
    send_frame(1'b0, q5, 0, 0);
    wait_frame_done(60);
    chk("postreset_data_out", 64'(bus.data_out), 64'h0070_6050_4030_2010);

    // randomized traffic
    noise_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      bit md;
      logic [7:0] body[$];
      int ng;
      ng = $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom);
        if (g == SOF) g = 8'h00;
        send_byte(g, $urandom_range(0, 2));
      end
      md = 1'($urandom_range(0, 1));
      body.delete();
      for (int k = 0; k < (md ? 5 : 10); k++) body.push_back(8'($urandom));
      done_delay = $urandom_range(0, 25);
      send_frame(md, body, 0, 1);
    end
    noise_en = 1'b0;
    repeat (60) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
